cpu_exec_units: RTL and testbench

CPU_EXEC_UNITS -- requirements
Module: cpu_exec_units

---
 rtl/cpu_exec_units.sv | 139 +++++++++++++
 tb/tb_cpu_exec_units.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_exec_units.sv
// Execution-side helpers for a small RV32I core: combinational ALU, machine-mode CSR file
// with a 64-bit cycle counter, and the load-data sign/zero extender.
module cpu_exec_units #(
  parameter logic [31:0] MISA_VALUE = 32'h40000100,
  parameter logic [31:0] HART_ID    = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_src_a,
  input  logic [31:0] alu_src_b,
  input  logic [3:0]  alu_control,
  output logic [31:0] alu_result,
  output logic        alu_zero,
  output logic        alu_borrow,
  output logic        alu_lt,
  input  logic [11:0] csr_raddr,
  output logic [31:0] csr_rdata,
  input  logic [11:0] csr_waddr,
  input  logic [31:0] csr_wdata,
  input  logic        csr_wenable,
  input  logic [31:0] ext_data,
  input  logic [2:0]  ext_control,
  output logic [31:0] ext_data_out
);

  function automatic logic [31:0] extend_load(input logic [31:0] d, input logic [2:0] f);
    case (f)
      3'b000:  extend_load = {{24{d[7]}}, d[7:0]};
      3'b001:  extend_load = {{16{d[15]}}, d[15:0]};
      3'b100:  extend_load = {24'd0, d[7:0]};
      3'b101:  extend_load = {16'd0, d[15:0]};
      default: extend_load = d;
    endcase
  endfunction

  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic [32:0]        diff;
  logic [4:0]         shamt;

  assign a_s   = alu_src_a;
  assign b_s   = alu_src_b;
  assign shamt = alu_src_b[4:0];
  // Borrow out of the 33-bit difference is the unsigned less-than flag.
  assign diff  = {1'b0, alu_src_a} - {1'b0, alu_src_b};

  assign alu_borrow = diff[32];
  assign alu_lt     = a_s < b_s;
  assign alu_zero   = (alu_result == 32'd0);

  always_comb begin
    alu_result = 32'd0;
    case (alu_control)
      4'b0000: alu_result = alu_src_a + alu_src_b;
      4'b1000: alu_result = diff[31:0];
      4'b0001: alu_result = alu_src_a << shamt;
      4'b0010: alu_result = {31'd0, alu_lt};
      4'b0011: alu_result = {31'd0, alu_borrow};
      4'b0100: alu_result = alu_src_a ^ alu_src_b;
      4'b0101: alu_result = alu_src_a >> shamt;
      4'b1101: alu_result = a_s >>> shamt;
      4'b0110: alu_result = alu_src_a | alu_src_b;
      4'b0111: alu_result = alu_src_a & alu_src_b;
      4'b1001: alu_result = alu_src_b;
      4'b1010: alu_result = alu_src_a & ~alu_src_b;
      default: alu_result = 32'd0;
    endcase
  end

  assign ext_data_out = extend_load(ext_data, ext_control);

  logic [31:0] mstatus_q, mie_q, mtvec_q, mscratch_q;
  logic [31:0] mepc_q, mcause_q, mtval_q, mip_q;
  logic [63:0] cycle_q;
  logic        wr_mcycle, wr_mcycleh;

  assign wr_mcycle  = csr_wenable && (csr_waddr == 12'hB00);
  assign wr_mcycleh = csr_wenable && (csr_waddr == 12'hB80);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_q  <= '0;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mip_q      <= '0;
    end else if (csr_wenable) begin
      case (csr_waddr)
        12'h300: mstatus_q  <= csr_wdata;
        12'h304: mie_q      <= csr_wdata;
        12'h305: mtvec_q    <= csr_wdata;
        12'h340: mscratch_q <= csr_wdata;
        12'h341: mepc_q     <= csr_wdata;
        12'h342: mcause_q   <= csr_wdata;
        12'h343: mtval_q    <= csr_wdata;
        12'h344: mip_q      <= csr_wdata;
        default: ;
      endcase
    end
  end

  // A software write to either half freezes the whole counter for that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q <= '0;
    end else if (wr_mcycle) begin
      cycle_q[31:0] <= csr_wdata;
    end else if (wr_mcycleh) begin
      cycle_q[63:32] <= csr_wdata;
    end else begin
      cycle_q <= cycle_q + 64'd1;
    end
  end

  always_comb begin
    csr_rdata = 32'd0;
    case (csr_raddr)
      12'h300: csr_rdata = mstatus_q;
      12'h301: csr_rdata = MISA_VALUE;
      12'h304: csr_rdata = mie_q;
      12'h305: csr_rdata = mtvec_q;
      12'h340: csr_rdata = mscratch_q;
      12'h341: csr_rdata = mepc_q;
      12'h342: csr_rdata = mcause_q;
      12'h343: csr_rdata = mtval_q;
      12'h344: csr_rdata = mip_q;
      12'hB00: csr_rdata = cycle_q[31:0];
      12'hB80: csr_rdata = cycle_q[63:32];
      12'hC00: csr_rdata = cycle_q[31:0];
      12'hC80: csr_rdata = cycle_q[63:32];
      12'hF14: csr_rdata = HART_ID;
      default: csr_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cpu_exec_units.sv
// Randomized self-checking bench for cpu_exec_units against an arithmetic reference model.
module tb_cpu_exec_units;

  localparam logic [31:0] MISA = 32'h40000100;
  localparam logic [31:0] HART = 32'd0;

  logic        clk, rst;
  logic [31:0] alu_src_a, alu_src_b, alu_result;
  logic [3:0]  alu_control;
  logic        alu_zero, alu_borrow, alu_lt;
  logic [11:0] csr_raddr, csr_waddr;
  logic [31:0] csr_rdata, csr_wdata;
  logic        csr_wenable;
  logic [31:0] ext_data, ext_data_out;
  logic [2:0]  ext_control;

  int errors = 0;
  int checks = 0;

  logic [11:0] rw_addr [8] = '{12'h300, 12'h304, 12'h305, 12'h340,
                               12'h341, 12'h342, 12'h343, 12'h344};
  logic [31:0] rw_val  [8];

  cpu_exec_units dut (
    .clk(clk), .rst(rst),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_borrow(alu_borrow), .alu_lt(alu_lt),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_waddr(csr_waddr),
    .csr_wdata(csr_wdata), .csr_wenable(csr_wenable),
    .ext_data(ext_data), .ext_control(ext_control), .ext_data_out(ext_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    longint unsigned ua = a;
    longint unsigned ub = b;
    int s = int'(b % 32);
    logic [31:0] r;
    case (op)
      4'd0:  r = 32'(ua + ub);
      4'd8:  r = 32'(ua + 64'h1_0000_0000 - ub);
      4'd1:  r = 32'(ua << s);
      4'd2:  r = ((a ^ 32'h80000000) < (b ^ 32'h80000000)) ? 32'd1 : 32'd0;
      4'd3:  r = (ua < ub) ? 32'd1 : 32'd0;
      4'd4:  r = a ^ b;
      4'd5:  r = 32'(ua >> s);
      4'd13: r = a[31] ? (32'(ua >> s) | ~(32'hFFFFFFFF >> s)) : 32'(ua >> s);
      4'd6:  r = a | b;
      4'd7:  r = a & b;
      4'd9:  r = b;
      4'd10: r = a & ~b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ext_ref(input logic [31:0] d, input logic [2:0] f);
    case (f)
      3'd0: return d[7]  ? (d & 32'hFF)   | 32'hFFFFFF00 : d & 32'hFF;
      3'd1: return d[15] ? (d & 32'hFFFF) | 32'hFFFF0000 : d & 32'hFFFF;
      3'd4: return d & 32'hFF;
      3'd5: return d & 32'hFFFF;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] csr_ref(input logic [11:0] addr);
    for (int i = 0; i < 8; i++) if (rw_addr[i] == addr) return rw_val[i];
    if (addr == 12'h301) return MISA;
    if (addr == 12'hF14) return HART;
    return 32'd0;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) rw_val[i] = 32'd0;
    for (int i = 0; i < 8; i++) begin
      csr_raddr = rw_addr[i]; #1;
      checks++;
      if (csr_rdata !== 32'd0) begin
        errors++; $display("FAIL reset_rw[%h]: got %h expected %h", rw_addr[i], csr_rdata, 32'd0);
      end
    end
    csr_raddr = 12'hB00; #1;
    checks++;
    if (csr_rdata !== 32'd0) begin
      errors++; $display("FAIL reset_mcycle: got %h expected %h", csr_rdata, 32'd0);
    end
    csr_raddr = 12'h301; #1;
    checks++;
    if (csr_rdata !== MISA) begin
      errors++; $display("FAIL reset_misa: got %h expected %h", csr_rdata, MISA);
    end
    @(negedge clk);
    rst = 1'b0;
    csr_raddr = 12'hB00;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk); #1;
      checks++;
      if (csr_rdata !== 32'(n)) begin
        errors++; $display("FAIL first_count%0d: got %h expected %h", n, csr_rdata, 32'(n));
      end
    end
  endtask

  task automatic test_alu_directed();
    logic [31:0] av [5] = '{32'd5, 32'h80000000, 32'h80000000, 32'h80000000, 32'd1};
    logic [31:0] bv [5] = '{32'd7, 32'h80000000, 32'h21, 32'h21, 32'h21};
    logic [3:0]  cv [5] = '{4'b1000, 4'b1000, 4'b1101, 4'b0101, 4'b0001};
    logic [31:0] rv [5] = '{32'hFFFFFFFE, 32'd0, 32'hC0000000, 32'h40000000, 32'd2};
    logic [2:0]  fv [3] = '{3'b1, 3'b0, 3'b0};
    for (int i = 0; i < 5; i++) begin
      alu_src_a = av[i]; alu_src_b = bv[i]; alu_control = cv[i]; #1;
      checks++;
      if (alu_result !== rv[i]) begin
        errors++; $display("FAIL alu_dir%0d: got %h expected %h", i, alu_result, rv[i]);
      end
      if (i < 2) begin
        fv[0] = {i == 1, i == 0, i == 0};
        checks++;
        if ({alu_zero, alu_borrow, alu_lt} !== fv[0]) begin
          errors++; $display("FAIL alu_flags%0d: got %b expected %b", i,
                             {alu_zero, alu_borrow, alu_lt}, fv[0]);
        end
      end
    end
  endtask

  task automatic test_alu_random();
    logic [31:0] a, b, exp;
    for (int i = 0; i < 300; i++) begin
      a = $urandom; b = $urandom;
      if (i % 7 == 0) b = a;
      if (i % 11 == 0) a = 32'h80000000 | (a & 32'hF);
      alu_src_a = a; alu_src_b = b; alu_control = 4'($urandom_range(0, 15)); #1;
      exp = alu_ref(a, b, alu_control);
      checks++;
      if (alu_result !== exp) begin
        errors++; $display("FAIL alu_rand op=%h a=%h b=%h: got %h expected %h",
                           alu_control, a, b, alu_result, exp);
      end
      checks++;
      if ({alu_zero, alu_borrow, alu_lt} !== {exp == 32'd0, alu_ref(a, b, 4'd3) == 32'd1,
                                              alu_ref(a, b, 4'd2) == 32'd1}) begin
        errors++; $display("FAIL alu_flags_rand a=%h b=%h: got %b", a, b,
                           {alu_zero, alu_borrow, alu_lt});
      end
    end
  endtask

  task automatic test_extend();
    logic [2:0]  fv [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [31:0] rv [5] = '{32'hFFFFFF80, 32'h80, 32'hFFFF8080, 32'h8080, 32'h8080};
    logic [31:0] exp;
    ext_data = 32'h00008080;
    for (int i = 0; i < 5; i++) begin
      ext_control = fv[i]; #1;
      checks++;
      if (ext_data_out !== rv[i]) begin
        errors++; $display("FAIL ext_dir f=%0d: got %h expected %h", fv[i], ext_data_out, rv[i]);
      end
    end
    for (int i = 0; i < 100; i++) begin
      ext_data = $urandom; ext_control = 3'($urandom_range(0, 7)); #1;
      exp = ext_ref(ext_data, ext_control);
      checks++;
      if (ext_data_out !== exp) begin
        errors++; $display("FAIL ext_rand f=%0d d=%h: got %h expected %h",
                           ext_control, ext_data, ext_data_out, exp);
      end
    end
  endtask

  task automatic test_csr_rw();
    logic [11:0] other [6] = '{12'h301, 12'hF14, 12'h7C0, 12'h306, 12'h000, 12'h345};
    logic [11:0] addr;
    logic [31:0] data, exp;
    int k;
    for (int it = 0; it < 40; it++) begin
      k = $urandom_range(0, 13);
      addr = (k < 8) ? rw_addr[k] : other[k - 8];
      data = (it == 0) ? 32'hDEADBEEF : $urandom;
      if (it == 0) addr = 12'h340;
      @(negedge clk);
      csr_waddr = addr; csr_wdata = data; csr_wenable = 1'b1; csr_raddr = addr; #1;
      exp = csr_ref(addr);
      checks++;
      if (csr_rdata !== exp) begin
        errors++; $display("FAIL csr_nobypass[%h]: got %h expected %h", addr, csr_rdata, exp);
      end
      for (int i = 0; i < 8; i++) if (rw_addr[i] == addr) rw_val[i] = data;
      @(negedge clk);
      csr_wenable = 1'b0;
      for (int i = 0; i < 14; i++) begin
        addr = (i < 8) ? rw_addr[i] : other[i - 8];
        csr_raddr = addr; #1;
        exp = csr_ref(addr);
        checks++;
        if (csr_rdata !== exp) begin
          errors++; $display("FAIL csr_read[%h]: got %h expected %h", addr, csr_rdata, exp);
        end
      end
    end
  endtask

  task automatic test_counter();
    logic [31:0] prev;
    @(negedge clk);
    csr_wenable = 1'b1; csr_waddr = 12'hB80; csr_wdata = 32'd0;
    @(negedge clk);
    csr_waddr = 12'hB00; csr_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    csr_wenable = 1'b0;
    csr_raddr = 12'hB00; #1;
    checks++;
    if (csr_rdata !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL cnt_written: got %h expected %h", csr_rdata, 32'hFFFFFFFF);
    end
    @(negedge clk);
    csr_raddr = 12'hB00; #1;
    checks++;
    if (csr_rdata !== 32'd0) begin
      errors++; $display("FAIL cnt_wrap_lo: got %h expected %h", csr_rdata, 32'd0);
    end
    csr_raddr = 12'hB80; #1;
    checks++;
    if (csr_rdata !== 32'd1) begin
      errors++; $display("FAIL cnt_wrap_hi: got %h expected %h", csr_rdata, 32'd1);
    end
    csr_raddr = 12'hC80; #1;
    checks++;
    if (csr_rdata !== 32'd1) begin
      errors++; $display("FAIL cnt_alias_hi: got %h expected %h", csr_rdata, 32'd1);
    end
    repeat (4) @(negedge clk);
    csr_raddr = 12'hC00; #1;
    checks++;
    if (csr_rdata !== 32'd4) begin
      errors++; $display("FAIL cnt_alias_lo: got %h expected %h", csr_rdata, 32'd4);
    end
    prev = csr_rdata;
    csr_wenable = 1'b1; csr_waddr = 12'hC00; csr_wdata = 32'h5555AAAA;
    @(negedge clk);
    csr_wenable = 1'b0; #1;
    checks++;
    if (csr_rdata !== prev + 32'd1) begin
      errors++; $display("FAIL cnt_ro_alias: got %h expected %h", csr_rdata, prev + 32'd1);
    end
    csr_wenable = 1'b1; csr_waddr = 12'hB80; csr_wdata = 32'h12345678;
    @(negedge clk);
    csr_wenable = 1'b0; csr_raddr = 12'hB80; #1;
    checks++;
    if (csr_rdata !== 32'h12345678) begin
      errors++; $display("FAIL cnt_hi_write: got %h expected %h", csr_rdata, 32'h12345678);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    csr_wenable = 1'b1; csr_waddr = 12'h341; csr_wdata = 32'h1234;
    @(negedge clk);
    csr_wenable = 1'b0; csr_raddr = 12'h341; #1;
    checks++;
    if (csr_rdata !== 32'h1234) begin
      errors++; $display("FAIL mepc_set: got %h expected %h", csr_rdata, 32'h1234);
    end
    #1 rst = 1'b1; #1;
    for (int i = 0; i < 8; i++) rw_val[i] = 32'd0;
    checks++;
    if (csr_rdata !== 32'd0) begin
      errors++; $display("FAIL mepc_async_rst: got %h expected %h", csr_rdata, 32'd0);
    end
    csr_raddr = 12'hB80; #1;
    checks++;
    if (csr_rdata !== 32'd0) begin
      errors++; $display("FAIL mcycleh_async_rst: got %h expected %h", csr_rdata, 32'd0);
    end
    csr_raddr = 12'hF14; alu_src_a = 32'd9; alu_src_b = 32'd3; alu_control = 4'b1000; #1;
    checks++;
    if ({csr_rdata, alu_result} !== {HART, 32'd6}) begin
      errors++; $display("FAIL comb_in_rst: got %h/%h expected %h/%h",
                         csr_rdata, alu_result, HART, 32'd6);
    end
    @(negedge clk);
    rst = 1'b0;
    csr_raddr = 12'hB00;
    @(negedge clk); #1;
    checks++;
    if (csr_rdata !== 32'd1) begin
      errors++; $display("FAIL cycle_restart: got %h expected %h", csr_rdata, 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1;
    alu_src_a = '0; alu_src_b = '0; alu_control = '0;
    csr_raddr = '0; csr_waddr = '0; csr_wdata = '0; csr_wenable = 1'b0;
    ext_data = '0; ext_control = '0;
    test_reset();
    test_alu_directed();
    test_alu_random();
    test_extend();
    test_csr_rw();
    test_counter();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
